// File: rtl/bsg_mem_arb_pkg.sv
// Shared types for the two-requester 1RW memory arbiter: FSM states, requester ids
// and the address-width helper.
package bsg_mem_arb_pkg;

  typedef enum logic {
    eINIT  = 1'b0,
    eREADY = 1'b1
  } state_e;

  typedef enum logic {
    eREQ0 = 1'b0,
    eREQ1 = 1'b1
  } req_id_e;

  // Address width that never collapses to zero bits for a single-word memory.
  function automatic int safe_clog2(input int x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_arb2_if.sv
// Bundle of both requester ports and the RAM port of bsg_mem_1rw_arb2.
// slave = arbiter side, master = requesters plus the RAM macro.
interface bsg_mem_1rw_arb2_if
  import bsg_mem_arb_pkg::*;
#(
  parameter width_p = "inv",
  parameter els_p   = "inv",
  localparam addr_width_lp = safe_clog2(els_p)
);

  logic                     r0_v_i,     r1_v_i;
  logic                     r0_w_i,     r1_w_i;
  logic [addr_width_lp-1:0] r0_addr_i,  r1_addr_i;
  logic [width_p-1:0]       r0_data_i,  r1_data_i;
  logic [width_p-1:0]       r0_mask_i,  r1_mask_i;
  logic                     r0_ready_o, r1_ready_o;
  logic                     r0_data_v_o, r1_data_v_o;
  logic [width_p-1:0]       data_o;

  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [addr_width_lp-1:0] mem_addr_o;
  logic [width_p-1:0]       mem_data_o;
  logic [width_p-1:0]       mem_w_mask_o;
  logic [width_p-1:0]       mem_data_i;

  logic                     init_done_o;

  modport slave (
    input  r0_v_i, r1_v_i, r0_w_i, r1_w_i, r0_addr_i, r1_addr_i,
           r0_data_i, r1_data_i, r0_mask_i, r1_mask_i, mem_data_i,
    output r0_ready_o, r1_ready_o, r0_data_v_o, r1_data_v_o, data_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, init_done_o
  );

  modport master (
    output r0_v_i, r1_v_i, r0_w_i, r1_w_i, r0_addr_i, r1_addr_i,
           r0_data_i, r1_data_i, r0_mask_i, r1_mask_i, mem_data_i,
    input  r0_ready_o, r1_ready_o, r0_data_v_o, r1_data_v_o, data_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, init_done_o
  );

endinterface

// File: rtl/bsg_mem_arb_rr2.sv
// Two-way round-robin grant: combinational grant from v, priority pointer that
// moves to the loser only when the granted request is consumed (yumi).
module bsg_mem_arb_rr2
  import bsg_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] v,
  input  logic       yumi,
  output logic [1:0] grant
);

  req_id_e ptr_r;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = v;
    if (v == 2'b11) begin
      grant = (ptr_r == eREQ0) ? 2'b01 : 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r <= eREQ0;
    end else if (yumi) begin
      ptr_r <= grant[0] ? eREQ1 : eREQ0;
    end
  end

endmodule

// File: rtl/bsg_mem_1rw_arb2.sv
// Arbitrates two requesters onto one single-port RAM with zero added latency.
// Optional power-up zero sweep of the RAM is compiled in with BSG_MEM_ARB_INIT_EN.
module bsg_mem_1rw_arb2
  import bsg_mem_arb_pkg::*;
#(
  parameter width_p = "inv",
  parameter els_p   = "inv",
  localparam addr_width_lp = safe_clog2(els_p)
)(
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_mem_1rw_arb2_if.slave bus
);

  state_e                   state_r, state_n;
  logic [1:0]               v_req;
  logic [1:0]               grant;
  logic                     accept;
  logic                     sel_w;
  logic [addr_width_lp-1:0] sel_addr;
  logic [width_p-1:0]       sel_data;
  logic [width_p-1:0]       sel_mask;
  logic [1:0]               rd_v_r;
  logic [width_p-1:0]       data_r;

`ifdef BSG_MEM_ARB_INIT_EN
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  logic [addr_width_lp-1:0] init_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      init_cnt_r <= '0;
    end else if (state_r == eINIT) begin
      init_cnt_r <= init_cnt_r + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
`ifdef BSG_MEM_ARB_INIT_EN
      state_r <= eINIT;
`else
      state_r <= eREADY;
`endif
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
`ifdef BSG_MEM_ARB_INIT_EN
    if (state_r == eINIT && init_cnt_r == last_addr_lp) begin
      state_n = eREADY;
    end
`endif
  end

  // Requests are invisible to the arbiter until the controller is ready.
  assign v_req  = {bus.r1_v_i, bus.r0_v_i} & {2{state_r == eREADY}};
  assign accept = |grant;

  bsg_mem_arb_rr2 u_rr2 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v         (v_req),
    .yumi      (accept),
    .grant     (grant)
  );

  assign bus.r0_ready_o  = grant[0];
  assign bus.r1_ready_o  = grant[1];
  assign bus.init_done_o = (state_r == eREADY);

  always_comb begin
    sel_w    = bus.r0_w_i;
    sel_addr = bus.r0_addr_i;
    sel_data = bus.r0_data_i;
    sel_mask = bus.r0_mask_i;
    if (grant[1]) begin
      sel_w    = bus.r1_w_i;
      sel_addr = bus.r1_addr_i;
      sel_data = bus.r1_data_i;
      sel_mask = bus.r1_mask_i;
    end
  end

  always_comb begin
    bus.mem_v_o      = accept;
    bus.mem_w_o      = accept & sel_w;
    bus.mem_addr_o   = sel_addr;
    bus.mem_data_o   = sel_data;
    bus.mem_w_mask_o = (accept & sel_w) ? sel_mask : '0;
`ifdef BSG_MEM_ARB_INIT_EN
    if (state_r == eINIT) begin
      bus.mem_v_o      = 1'b1;
      bus.mem_w_o      = 1'b1;
      bus.mem_addr_o   = init_cnt_r;
      bus.mem_data_o   = '0;
      bus.mem_w_mask_o = '1;
    end
`endif
  end

  // Read response tracks the requester that owned the read one cycle earlier.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_r <= 2'b00;
      data_r <= '0;
    end else begin
      rd_v_r <= (accept && !sel_w) ? grant : 2'b00;
      if (|rd_v_r) begin
        data_r <= bus.mem_data_i;
      end
    end
  end

  assign bus.r0_data_v_o = rd_v_r[0];
  assign bus.r1_data_v_o = rd_v_r[1];
  assign bus.data_o      = (|rd_v_r) ? bus.mem_data_i : data_r;

endmodule

// File: doc/bsg_mem_1rw_arb2.md
BSG_MEM_1RW_ARB2 -- requirements
Module: bsg_mem_1rw_arb2

Interface
REQ-001 SHALL have parameter width_p, default "inv", data/mask width in bits.
REQ-002 SHALL have parameter els_p, default "inv", number of memory words; addr_width_lp = BSG_SAFE_CLOG2(els_p).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports rN_v_i / rN_w_i (N=0,1)  input  1 each  request valid / write-not-read.
REQ-006 SHALL have ports rN_addr_i  input  addr_width_lp  request address.
REQ-007 SHALL have ports rN_data_i, rN_mask_i  input  width_p each  write data, per-bit write mask.
REQ-008 SHALL have ports rN_ready_o  output  1  request accepted this cycle when rN_v_i & rN_ready_o.
REQ-009 SHALL have ports rN_data_v_o  output  1  read data for requester N valid on data_o.
REQ-010 SHALL have port data_o  output  width_p  read data, shared by both requesters.
REQ-011 SHALL have ports mem_v_o, mem_w_o  output  1 each  RAM access enable / write.
REQ-012 SHALL have ports mem_addr_o / mem_data_o / mem_w_mask_o  output  addr_width_lp / width_p / width_p  RAM address, write data, bit mask.
REQ-013 SHALL have port mem_data_i  input  width_p  RAM read data, valid one cycle after a read access.
REQ-014 SHALL have port init_done_o  output  1  high once the controller accepts requests.

Function
REQ-015 SHALL implement FSM states eINIT and eREADY; eINIT -> eREADY after the final init write; eREADY is terminal until reset.
REQ-016 SHALL, in eREADY, grant at most one requester per cycle, combinationally from rN_v_i; both rN_ready_o low in eINIT.
REQ-017 SHALL grant the sole valid requester if only one is valid; if both are valid, grant the one indicated by a round-robin priority pointer.
REQ-018 SHALL toggle the priority pointer to favour the non-granted requester only on an accepted handshake; pointer holds otherwise.
REQ-019 SHALL drive mem_v_o = accept, and mem_w_o/addr/data/mask from the granted requester in the same cycle (zero added latency).
REQ-020 SHALL force mem_w_mask_o to all-zero on reads.
REQ-021 SHALL, for an accepted read, pulse rN_data_v_o for exactly one cycle, the cycle after acceptance, with data_o = mem_data_i.
REQ-022 SHALL produce no response for writes; both rN_data_v_o stay low.
REQ-023 SHALL sustain one accepted request per cycle back-to-back; a read response and a new acceptance may coincide.
REQ-024 SHALL hold data_o stable at last read value when no rN_data_v_o is asserted.
REQ-025 SHALL keep a non-granted valid request pending without loss; requesters hold payload until ready.

Reset
REQ-026 SHALL on reset_n_i low asynchronously set: FSM to eINIT (eREADY if init compiled out), init counter 0, pointer to requester 0, rN_data_v_o 0, data_o register 0, init_done_o 0 (1 if init compiled out).
REQ-027 SHALL drop any in-flight read response when reset asserts mid-operation; no rN_data_v_o after deassertion until a new read is accepted.

Configuration
REQ-028 SHALL compile the init sweep in only when macro BSG_MEM_ARB_INIT_EN is defined: eINIT writes all-zero data with all-ones mask to addresses 0..els_p-1, one per cycle, then enters eREADY and raises init_done_o (els_p cycles after reset release).
REQ-029 SHALL, without BSG_MEM_ARB_INIT_EN, omit the init counter, start in eREADY, and hold init_done_o high after reset.

Structure
REQ-030 SHALL place the FSM state enum (eINIT, eREADY) and the requester-id typedef in shared package bsg_mem_arb_pkg.
REQ-031 SHALL implement the 2-way round-robin grant and pointer in sub-module bsg_mem_arb_rr2 (inputs v[1:0], yumi; outputs grant[1:0]).

Verification
REQ-032 SHALL verify init: els_p=16, macro defined -> mem_v_o/mem_w_o high 16 cycles, addr 0..15, mask all-ones, init_done_o rises on cycle 16, ready low throughout.
REQ-033 SHALL verify single read: r0 read addr 5 holding 0xA5 -> r0_ready_o same cycle, r0_data_v_o next cycle with data_o=0xA5, r1_data_v_o low.
REQ-034 SHALL verify contention: both valid for 4 cycles, pointer=0 -> grants r0,r1,r0,r1.
REQ-035 SHALL verify masked write: r1 writes data 0xFF mask 0x0F to word 0x00 -> subsequent read returns 0x0F, no write response pulse.
REQ-036 SHALL verify reset mid-read: reset_n_i low the cycle after accepting a read -> no rN_data_v_o after release, pointer back to 0.
REQ-037 SHALL verify macro undefined: init_done_o high and rN_ready_o available the first cycle after reset release.
